sd_spi_card_model: RTL and testbench

- SPI-mode SD card responder. It is the device end of the link driven by sd_card_top, and replaces a physical card for bench and loop-back board tests.
- Decodes 6-byte commands on sd_mosi, returns R1/R7 responses, and serves single-block read (CMD17) and write (CMD24) from one internal sector buffer.
- Oversamples sd_ncs/sd_dclk/sd_mosi on sys_clk. sd_dclk must be <= sys_clk/8.

---
 rtl/sd_spi_card_model.sv | 325 ++++++++++++++++++++++++++++++++
 tb/tb_sd_spi_card_model.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/sd_spi_card_model.sv
// SPI-mode SD card responder: decodes host commands, answers R1/R7/OCR and
// serves single-block read/write from one internal sector buffer.
//
// state      | meaning
// S_CMD      | hunt for start bit, collect 6 command bytes, tx 0xFF
// S_NCR      | filler 0xFF bytes before the response
// S_RESP     | R1 plus any trailing R7/OCR bytes
// S_RD_TOKEN | start-block token 0xFE
// S_RD_DATA  | stream sector buffer to host
// S_RD_CRC   | two dummy CRC bytes
// S_WR_TOKEN | wait for host 0xFE (a new command may also start here)
// S_WR_DATA  | capture host bytes into sector buffer
// S_WR_CRC   | swallow two CRC bytes
// S_WR_RESP  | data-accepted token 0x05
// S_WR_BUSY  | hold MISO low for the programming time
module sd_spi_card_model #(
    parameter int SECTOR_BYTES = 512,
    parameter int NCR_BYTES    = 1,
    parameter int INIT_POLLS   = 2,
    parameter int BUSY_BYTES   = 4
) (
    input  logic        sys_clk,
    input  logic        rst_n,
    input  logic        sd_ncs,
    input  logic        sd_dclk,
    input  logic        sd_mosi,
    output logic        sd_miso,
    output logic        cmd_valid,
    output logic [5:0]  cmd_index,
    output logic [31:0] cmd_arg,
    output logic        card_ready,
    output logic        wr_done
);
    localparam int AW = $clog2(SECTOR_BYTES);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] SECT_LAST = CW'(SECTOR_BYTES - 1);
    localparam logic [CW-1:0] NCR_LAST  = CW'(NCR_BYTES - 1);
    localparam logic [CW-1:0] BUSY_LAST = CW'(BUSY_BYTES - 1);
    localparam logic [7:0]    POLLS     = 8'(INIT_POLLS);

    typedef enum logic [3:0] {
        S_CMD, S_NCR, S_RESP, S_RD_TOKEN, S_RD_DATA, S_RD_CRC,
        S_WR_TOKEN, S_WR_DATA, S_WR_CRC, S_WR_RESP, S_WR_BUSY
    } state_t;

    typedef enum logic [2:0] { K_R1, K_R7, K_OCR, K_RD, K_WR } kind_t;

    logic          ncs_meta_q, ncs_q, dclk_meta_q, dclk_q, dclk_prev_q;
    logic          mosi_meta_q, mosi_q;
    logic [2:0]    bit_cnt_q;
    logic [6:0]    rx_sr_q;
    logic [6:0]    tx_sr_q;
    logic          load_q;
    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [5:0]    idx_sr_q;
    logic [31:0]   arg_sr_q;
    kind_t         kind_q;
    logic [7:0]    r1_q;
    logic          idle_q, app_q;
    logic [7:0]    poll_q;
    logic [7:0]    mem_q [SECTOR_BYTES];

    logic          dclk_rise, dclk_fall, byte_done, mem_we;
    logic [7:0]    rx_byte, tx_byte;
    logic [CW-1:0] resp_last;
    logic          dec_idle, dec_ready, dec_app, dec_illegal;
    logic [7:0]    dec_poll, dec_r1;
    kind_t         dec_kind;

    assign dclk_rise = dclk_q & ~dclk_prev_q;
    assign dclk_fall = ~dclk_q & dclk_prev_q;
    assign byte_done = dclk_rise && !ncs_q && (bit_cnt_q == 3'd7);
    assign rx_byte   = {rx_sr_q, mosi_q};
    assign mem_we    = byte_done && (state_q == S_WR_DATA);
    assign resp_last = (kind_q == K_R7 || kind_q == K_OCR) ? CW'(4) : '0;

    // Two-flop synchronisers for the host-side SPI pins plus dclk edge history.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            ncs_meta_q  <= 1'b1;
            ncs_q       <= 1'b1;
            dclk_meta_q <= 1'b0;
            dclk_q      <= 1'b0;
            dclk_prev_q <= 1'b0;
            mosi_meta_q <= 1'b1;
            mosi_q      <= 1'b1;
        end else begin
            ncs_meta_q  <= sd_ncs;
            ncs_q       <= ncs_meta_q;
            dclk_meta_q <= sd_dclk;
            dclk_q      <= dclk_meta_q;
            dclk_prev_q <= dclk_q;
            mosi_meta_q <= sd_mosi;
            mosi_q      <= mosi_meta_q;
        end
    end

    // Command decode: R1 value and side effects, evaluated on the CRC byte.
    always_comb begin
        dec_idle    = idle_q;
        dec_ready   = card_ready;
        dec_app     = 1'b0;
        dec_poll    = poll_q;
        dec_kind    = K_R1;
        dec_illegal = 1'b0;
        if (app_q && idx_sr_q == 6'd41) begin
            if (poll_q < POLLS) begin
                dec_poll = poll_q + 8'd1;
            end else begin
                dec_idle  = 1'b0;
                dec_ready = 1'b1;
            end
        end else begin
            case (idx_sr_q)
                6'd0:  dec_idle = 1'b1;
                6'd8:  dec_kind = K_R7;
                6'd55: dec_app  = 1'b1;
                6'd58: dec_kind = K_OCR;
                6'd17: if (card_ready) dec_kind = K_RD; else dec_illegal = 1'b1;
                6'd24: if (card_ready) dec_kind = K_WR; else dec_illegal = 1'b1;
                default: dec_illegal = 1'b1;
            endcase
        end
        dec_r1 = {5'b0, dec_illegal, 1'b0, dec_idle};
    end

    // Byte to present for the current state/index, loaded at the next byte boundary.
    always_comb begin
        tx_byte = 8'hFF;
        case (state_q)
            S_RESP: begin
                if (cnt_q == '0) begin
                    tx_byte = r1_q;
                end else if (kind_q == K_R7) begin
                    case (cnt_q[2:0])
                        3'd1, 3'd2: tx_byte = 8'h00;
                        3'd3:       tx_byte = 8'h01;
                        default:    tx_byte = cmd_arg[7:0];
                    endcase
                end else begin
                    case (cnt_q[2:0])
                        3'd1:    tx_byte = 8'hC0;
                        3'd2:    tx_byte = 8'hFF;
                        3'd3:    tx_byte = 8'h80;
                        default: tx_byte = 8'h00;
                    endcase
                end
            end
            S_RD_TOKEN: tx_byte = 8'hFE;
            S_RD_DATA:  tx_byte = mem_q[cnt_q[AW-1:0]];
            S_WR_RESP:  tx_byte = 8'h05;
            S_WR_BUSY:  tx_byte = 8'h00;
            default:    tx_byte = 8'hFF;
        endcase
    end

    // Sector buffer write port; contents deliberately survive reset.
    always_ff @(posedge sys_clk) begin
        if (mem_we) mem_q[cnt_q[AW-1:0]] <= rx_byte;
    end

    // Bit engine and protocol FSM; byte-level decisions happen on the 8th rising edge.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            sd_miso    <= 1'b1;
            cmd_valid  <= 1'b0;
            cmd_index  <= '0;
            cmd_arg    <= '0;
            card_ready <= 1'b0;
            wr_done    <= 1'b0;
            bit_cnt_q  <= '0;
            rx_sr_q    <= '0;
            tx_sr_q    <= '1;
            load_q     <= 1'b0;
            state_q    <= S_CMD;
            cnt_q      <= '0;
            idx_sr_q   <= '0;
            arg_sr_q   <= '0;
            kind_q     <= K_R1;
            r1_q       <= '0;
            idle_q     <= 1'b1;
            app_q      <= 1'b0;
            poll_q     <= '0;
        end else begin
            cmd_valid <= 1'b0;
            wr_done   <= 1'b0;
            if (ncs_q) begin
                bit_cnt_q <= '0;
                load_q    <= 1'b0;
                tx_sr_q   <= '1;
                sd_miso   <= 1'b1;
                state_q   <= S_CMD;
                cnt_q     <= '0;
            end else begin
                if (dclk_rise) begin
                    rx_sr_q   <= rx_byte[6:0];
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) load_q <= 1'b1;
                end
                if (dclk_fall) begin
                    if (load_q) begin
                        sd_miso <= tx_byte[7];
                        tx_sr_q <= tx_byte[6:0];
                        load_q  <= 1'b0;
                    end else begin
                        sd_miso <= tx_sr_q[6];
                        tx_sr_q <= {tx_sr_q[5:0], 1'b1};
                    end
                end
                if (byte_done) begin
                    case (state_q)
                        S_CMD: begin
                            if (cnt_q == '0) begin
                                if (rx_byte[7:6] == 2'b01) begin
                                    idx_sr_q <= rx_byte[5:0];
                                    cnt_q    <= CW'(1);
                                end
                            end else if (cnt_q < CW'(5)) begin
                                arg_sr_q <= {arg_sr_q[23:0], rx_byte};
                                cnt_q    <= cnt_q + 1'b1;
                            end else begin
                                cmd_index  <= idx_sr_q;
                                cmd_arg    <= arg_sr_q;
                                cmd_valid  <= 1'b1;
                                r1_q       <= dec_r1;
                                kind_q     <= dec_kind;
                                idle_q     <= dec_idle;
                                card_ready <= dec_ready;
                                app_q      <= dec_app;
                                poll_q     <= dec_poll;
                                state_q    <= S_NCR;
                                cnt_q      <= '0;
                            end
                        end
                        S_NCR: begin
                            if (cnt_q == NCR_LAST) begin
                                state_q <= S_RESP;
                                cnt_q   <= '0;
                            end else begin
                                cnt_q <= cnt_q + 1'b1;
                            end
                        end
                        S_RESP: begin
                            if (cnt_q == resp_last) begin
                                cnt_q <= '0;
                                case (kind_q)
                                    K_RD:    state_q <= S_RD_TOKEN;
                                    K_WR:    state_q <= S_WR_TOKEN;
                                    default: state_q <= S_CMD;
                                endcase
                            end else begin
                                cnt_q <= cnt_q + 1'b1;
                            end
                        end
                        S_RD_TOKEN: begin
                            state_q <= S_RD_DATA;
                            cnt_q   <= '0;
                        end
                        S_RD_DATA: begin
                            if (cnt_q == SECT_LAST) begin
                                state_q <= S_RD_CRC;
                                cnt_q   <= '0;
                            end else begin
                                cnt_q <= cnt_q + 1'b1;
                            end
                        end
                        S_RD_CRC: begin
                            if (cnt_q == CW'(1)) begin
                                state_q <= S_CMD;
                                cnt_q   <= '0;
                            end else begin
                                cnt_q <= cnt_q + 1'b1;
                            end
                        end
                        S_WR_TOKEN: begin
                            if (rx_byte == 8'hFE) begin
                                state_q <= S_WR_DATA;
                                cnt_q   <= '0;
                            end else if (rx_byte[7:6] == 2'b01) begin
                                // host gave up on the write and started a new command
                                idx_sr_q <= rx_byte[5:0];
                                state_q  <= S_CMD;
                                cnt_q    <= CW'(1);
                            end
                        end
                        S_WR_DATA: begin
                            if (cnt_q == SECT_LAST) begin
                                state_q <= S_WR_CRC;
                                cnt_q   <= '0;
                            end else begin
                                cnt_q <= cnt_q + 1'b1;
                            end
                        end
                        S_WR_CRC: begin
                            if (cnt_q == CW'(1)) begin
                                wr_done <= 1'b1;
                                state_q <= S_WR_RESP;
                                cnt_q   <= '0;
                            end else begin
                                cnt_q <= cnt_q + 1'b1;
                            end
                        end
                        S_WR_RESP: begin
                            state_q <= S_WR_BUSY;
                            cnt_q   <= '0;
                        end
                        S_WR_BUSY: begin
                            if (cnt_q == BUSY_LAST) begin
                                state_q <= S_CMD;
                                cnt_q   <= '0;
                            end else begin
                                cnt_q <= cnt_q + 1'b1;
                            end
                        end
                        default: begin
                            state_q <= S_CMD;
                            cnt_q   <= '0;
                        end
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_sd_spi_card_model.sv
// Bench for sd_spi_card_model: SPI host driver pushes expected MISO bytes and
// commands into queues; independent monitors pop and compare.
module tb_sd_spi_card_model;
    logic        sys_clk = 1'b0;
    logic        rst_n, sd_ncs, sd_dclk, sd_mosi;
    logic        sd_miso, cmd_valid, card_ready, wr_done;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;

    logic [8:0]  exp_q [$];
    int          tag_q [$];
    logic [37:0] cmd_q [$];

    logic [7:0]  mon_sh = 8'h00;
    int          mon_bits = 0;
    logic [8:0]  mon_e;
    int          mon_t;
    logic [37:0] cmd_e;

    sd_spi_card_model #(
        .SECTOR_BYTES(512), .NCR_BYTES(1), .INIT_POLLS(2), .BUSY_BYTES(4)
    ) dut (
        .sys_clk(sys_clk), .rst_n(rst_n), .sd_ncs(sd_ncs), .sd_dclk(sd_dclk),
        .sd_mosi(sd_mosi), .sd_miso(sd_miso), .cmd_valid(cmd_valid),
        .cmd_index(cmd_index), .cmd_arg(cmd_arg), .card_ready(card_ready),
        .wr_done(wr_done)
    );

    always #5 sys_clk = ~sys_clk;

    // MISO byte monitor: assembles bytes at host sample edges, pops scoreboard.
    always @(posedge sd_dclk or posedge sd_ncs) begin
        if (sd_ncs) begin
            mon_bits = 0;
        end else begin
            mon_sh = {mon_sh[6:0], sd_miso};
            mon_bits++;
            if (mon_bits == 8) begin
                mon_bits = 0;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL miso_unexpected: got %02h with empty scoreboard", mon_sh);
                end else begin
                    mon_e = exp_q.pop_front();
                    mon_t = tag_q.pop_front();
                    if (mon_e[8]) begin
                        checks++;
                        if (mon_sh !== mon_e[7:0]) begin
                            errors++;
                            $display("FAIL miso_byte step %0d: got %02h want %02h",
                                     mon_t, mon_sh, mon_e[7:0]);
                        end
                    end
                end
            end
        end
    end

    // Command/pulse monitor on the system clock, away from the active edge.
    always @(negedge sys_clk) begin
        if (rst_n && wr_done) wr_cnt++;
        if (rst_n && cmd_valid) begin
            checks++;
            if (cmd_q.size() == 0) begin
                errors++;
                $display("FAIL cmd_unexpected: got idx %0d arg %08h", cmd_index, cmd_arg);
            end else begin
                cmd_e = cmd_q.pop_front();
                if ({cmd_index, cmd_arg} !== cmd_e) begin
                    errors++;
                    $display("FAIL cmd_decode: got idx %0d arg %08h want idx %0d arg %08h",
                             cmd_index, cmd_arg, cmd_e[37:32], cmd_e[31:0]);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, got, want);
        end
    endtask

    // One mode-0 byte: 40 ns low, 40 ns high per bit (sys_clk/8).
    task automatic spi_byte(input logic [7:0] tx, input logic chk_en,
                            input logic [7:0] exp, input int tag);
        exp_q.push_back({chk_en, exp});
        tag_q.push_back(tag);
        for (int i = 7; i >= 0; i--) begin
            sd_mosi = tx[i];
            #40 sd_dclk = 1'b1;
            #40 sd_dclk = 1'b0;
        end
    endtask

    task automatic resp(input logic [7:0] exp, input int tag);
        spi_byte(8'hFF, 1'b1, exp, tag);
    endtask

    // Six command bytes (card idles at 0xFF) plus the single NCR filler byte.
    task automatic send_cmd(input logic [5:0] idx, input logic [31:0] arg,
                            input logic [7:0] crc, input int tag);
        cmd_q.push_back({idx, arg});
        spi_byte({2'b01, idx}, 1'b1, 8'hFF, tag);
        spi_byte(arg[31:24], 1'b1, 8'hFF, tag);
        spi_byte(arg[23:16], 1'b1, 8'hFF, tag);
        spi_byte(arg[15:8],  1'b1, 8'hFF, tag);
        spi_byte(arg[7:0],   1'b1, 8'hFF, tag);
        spi_byte(crc,        1'b1, 8'hFF, tag);
        spi_byte(8'hFF,      1'b1, 8'hFF, tag);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n   = 1'b0;
        sd_ncs  = 1'b1;
        sd_dclk = 1'b0;
        sd_mosi = 1'b1;
        repeat (3) @(posedge sys_clk);
        #2;
        chk("rst_miso",       32'(sd_miso),    32'd1);
        chk("rst_cmd_valid",  32'(cmd_valid),  32'd0);
        chk("rst_cmd_index",  32'(cmd_index),  32'd0);
        chk("rst_cmd_arg",    cmd_arg,         32'd0);
        chk("rst_card_ready", 32'(card_ready), 32'd0);
        chk("rst_wr_done",    32'(wr_done),    32'd0);
        @(posedge sys_clk);
        rst_n = 1'b1;
        @(posedge sys_clk);
        #7;
        sd_ncs = 1'b0;
        #100;

        send_cmd(6'd0, 32'h0, 8'h95, 1);
        resp(8'h01, 1);

        send_cmd(6'd8, 32'h0000_01AA, 8'h87, 2);
        resp(8'h01, 2); resp(8'h00, 2); resp(8'h00, 2); resp(8'h01, 2); resp(8'hAA, 2);

        send_cmd(6'd17, 32'h0, 8'hFF, 3);
        resp(8'h05, 3);
        chk("ready_early", 32'(card_ready), 32'd0);

        for (int n = 0; n < 3; n++) begin
            send_cmd(6'd55, 32'h0, 8'h65, 4);
            resp(8'h01, 4);
            send_cmd(6'd41, 32'h4000_0000, 8'h77, 5);
            resp((n < 2) ? 8'h01 : 8'h00, 5);
            chk("ready_after_acmd41", 32'(card_ready), 32'(n == 2));
        end

        send_cmd(6'd58, 32'h0, 8'hFD, 6);
        resp(8'h00, 6); resp(8'hC0, 6); resp(8'hFF, 6); resp(8'h80, 6); resp(8'h00, 6);

        send_cmd(6'd24, 32'h0000_0010, 8'hFF, 7);
        resp(8'h00, 7);
        spi_byte(8'hFF, 1'b1, 8'hFF, 7);
        spi_byte(8'hFE, 1'b1, 8'hFF, 7);
        for (int k = 0; k < 512; k++) spi_byte(8'(k), 1'b1, 8'hFF, 8);
        spi_byte(8'hFF, 1'b1, 8'hFF, 9);
        chk("wr_done_early", 32'(wr_cnt), 32'd0);
        spi_byte(8'hFF, 1'b1, 8'hFF, 9);
        #100;
        chk("wr_done_pulse", 32'(wr_cnt), 32'd1);
        resp(8'h05, 10);
        for (int b = 0; b < 4; b++) resp(8'h00, 10);
        resp(8'hFF, 10);

        send_cmd(6'd17, 32'h0000_0010, 8'hFF, 11);
        resp(8'h00, 11);
        resp(8'hFE, 11);
        for (int k = 0; k < 512; k++) resp(8'(k), 12);
        resp(8'hFF, 13); resp(8'hFF, 13); resp(8'hFF, 13);

        send_cmd(6'd17, 32'h0, 8'hFF, 14);
        resp(8'h00, 14);
        resp(8'hFE, 14);
        for (int k = 0; k < 100; k++) resp(8'(k), 15);
        sd_ncs = 1'b1;
        #100;
        chk("abort_miso_high", 32'(sd_miso), 32'd1);
        #100;
        sd_ncs = 1'b0;
        #100;
        send_cmd(6'd0, 32'h0, 8'h95, 16);
        resp(8'h01, 16);

        #200;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        chk("cmd_queue_drained",  32'(cmd_q.size()), 32'd0);
        chk("wr_done_total",      32'(wr_cnt),       32'd1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
